point_scheduler: RTL
====================

Name: point_scheduler

Overview:
Controller that sequences the point generator on behalf of the game logic.
- Detects when either snake eats the current point and credits the score.
- Requests a new candidate position from the generator and validates it against the map occupancy lookup.
- Retries rejected candidates and publishes the accepted point.
- Sits between the game FSM / snake movers and the generator, in the clk_75 domain.

Parameters:
GRID_X, 32, number of valid columns; valid x is 0..GRID_X-1
GRID_Y, 24, number of valid rows; valid y is 0..GRID_Y-1
MAX_RETRY, 15, candidates rejected in a row before declaring failure (1..255)
SCORE_W, 8, width of each score counter

Ports:
clk_75  in  1  system clock
rst  in  1  reset, synchronous to clk_75, active-high
mode  in  game_mode  MENU/GAME from the game FSM
tick  in  1  one-cycle game-step strobe (clk_div edge, already synchronised)
eat_p1, eat_p2  in  1  head of snake 1/2 is on point_x/point_y; sampled only on tick
head1_x, head1_y, head2_x, head2_y  in  5  head positions (used only with the optional feature)
gen_req  out  1  one-cycle pulse, drives the generator's colision input
gen_x, gen_y  in  5  candidate from the generator
gen_rdy  in  1  one-cycle pulse; gen_x/gen_y are valid in that cycle
occ_x, occ_y  out  5  occupancy lookup address
occ_hit  in  1  cell occupied; valid one cycle after occ_x/occ_y are driven
point_x, point_y  out  5  published point
point_valid  out  1  point_x/point_y are live
score_p1, score_p2  out  SCORE_W  saturating scores
busy  out  1  state is not IDLE and not FAIL
fail  out  1  sticky; set when MAX_RETRY is exhausted

Behaviour:
- Reset: every output is 0; state IDLE; retry_cnt 0.
- States: IDLE, REQ, WAIT_RDY, CHECK, EVAL, PUBLISH, FAIL.
- IDLE:
  - mode==GAME and point_valid==0 and fail==0 -> REQ (initial spawn).
  - mode==GAME and point_valid and tick and (eat_p1|eat_p2) -> credit scores, clear point_valid, -> REQ.
- REQ: gen_req=1 for exactly one cycle -> WAIT_RDY.
- WAIT_RDY:
  - Hold until gen_rdy; capture gen_x/gen_y into the candidate register -> CHECK.
  - gen_rdy pulses in any other state are ignored.
- CHECK: drive occ_x/occ_y = candidate (held through EVAL) -> EVAL.
- EVAL:
  - Reject if occ_hit, gen_x>=GRID_X, or gen_y>=GRID_Y (plus the optional guard).
  - On reject: retry_cnt+1. If the incremented value equals MAX_RETRY -> FAIL, else -> REQ.
  - On accept -> PUBLISH.
- PUBLISH: load point_x/point_y, set point_valid=1, clear retry_cnt -> IDLE.
- FAIL: fail=1, point_valid=0; stay here until mode!=GAME.
- Minimum latency, with gen_rdy arriving the cycle after gen_req:
  - tick with eat at cycle T -> gen_req at T+1 -> point_valid high at T+5.
- Simultaneous eat_p1 and eat_p2: both scores increment.
- Scores saturate at 2^SCORE_W-1.
- eat inputs without tick, or while point_valid==0, are ignored.
- mode!=GAME in any state, taking priority over every other transition:
  - next state IDLE; point_valid=0, fail=0, retry_cnt=0.
  - Scores hold their values.
- MENU->GAME transition (mode was not GAME last cycle): scores cleared to 0 in that cycle.
- rst asserted mid-sequence: every register returns to its reset value on the next clock; a pending gen_rdy is dropped.

Optional Feature:
Macro POINT_SCHED_SPAWN_GUARD_EN.
- Defined: EVAL also rejects a candidate whose Manhattan distance is <=1 from either head (head1_x/y, head2_x/y). Use 6-bit unsigned absolute differences. A rejection counts toward retry_cnt.
- Undefined: head ports exist but are unused; behaviour is exactly as above.

Decomposition:
- snake_pkg gains:
  - point_sched_state_e enum with the seven states.
  - GRID_X_DEF / GRID_Y_DEF constants.
  - point_t struct {x,y 5 bits each}.
- game_mode is reused from snake_pkg.
- One sub-module: point_score_ctr (SCORE_W saturating counter with clear and inc inputs), instantiated twice.

Test Plan:
- Reset then mode=GAME; generator returns (3,4) with occ_hit=0 -> one gen_req pulse, point_valid=1, point=(3,4), scores 0.
- tick with eat_p1=1 -> score_p1=1, point_valid drops the next cycle, gen_req the cycle after; next candidate (10,7) published.
- Candidates (31,30) (y out of range), then occupied (5,5), then free (6,6) -> 3 gen_req pulses, point=(6,6), retry_cnt cleared.
- MAX_RETRY=3 with occ_hit held at 1 -> 3 gen_req pulses, then fail=1, point_valid=0, busy=0. mode=MENU -> fail=0.
- eat_p1 and eat_p2 together on a tick with score_p2=255 (SCORE_W=8) -> score_p1 +1, score_p2 stays 255; mode MENU->GAME clears both.
- mode=MENU while in WAIT_RDY, then a late gen_rdy arrives -> state IDLE, no capture, point_valid=0. With POINT_SCHED_SPAWN_GUARD_EN, candidate adjacent to head1 is rejected and regenerated.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake game: game mode, point scheduler states, point struct.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package snake_pkg;

  typedef enum logic {
    MENU = 1'b0,
    GAME = 1'b1
  } game_mode;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_CHECK    = 3'd3,
    ST_EVAL     = 3'd4,
    ST_PUBLISH  = 3'd5,
    ST_FAIL     = 3'd6
  } point_sched_state_e;

  localparam int GRID_X_DEF = 32;
  localparam int GRID_Y_DEF = 24;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } point_t;

  // Unsigned |a-b| widened to 6 bits so two of them can be summed without overflow.
  function automatic logic [5:0] absdiff6(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] wa;
    logic [5:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/point_score_ctr.sv
// Saturating score counter with synchronous clear (clear wins over increment).
// Latency: count visible one cycle after i_inc/i_clr.
// Backpressure: none; increments beyond all-ones are silently dropped.
module point_score_ctr #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear has priority; increment stops at the all-ones value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/point_scheduler.sv
// Sequences the point generator: detects eats, credits scores, requests/validates candidates, publishes the point.
// Latency: tick+eat at T -> gen_req at T+1 -> point_valid at T+5 when gen_rdy follows gen_req directly.
// Backpressure: waits indefinitely for gen_rdy; gives up (sticky fail) after MAX_RETRY consecutive rejects.
// Optional: define POINT_SCHED_SPAWN_GUARD_EN to also reject candidates within Manhattan distance 1 of a head.
module point_scheduler
  import snake_pkg::*;
#(
  parameter int GRID_X    = GRID_X_DEF,
  parameter int GRID_Y    = GRID_Y_DEF,
  parameter int MAX_RETRY = 15,
  parameter int SCORE_W   = 8
) (
  input  logic               clk_75,
  input  logic               rst,
  input  game_mode           mode,
  input  logic               tick,
  input  logic               eat_p1,
  input  logic               eat_p2,
  input  logic [4:0]         head1_x,
  input  logic [4:0]         head1_y,
  input  logic [4:0]         head2_x,
  input  logic [4:0]         head2_y,
  output logic               gen_req,
  input  logic [4:0]         gen_x,
  input  logic [4:0]         gen_y,
  input  logic               gen_rdy,
  output logic [4:0]         occ_x,
  output logic [4:0]         occ_y,
  input  logic               occ_hit,
  output logic [4:0]         point_x,
  output logic [4:0]         point_y,
  output logic               point_valid,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               busy,
  output logic               fail
);

  point_sched_state_e r_state;
  point_sched_state_e w_state_nxt;
  point_t             r_cand;
  point_t             r_point;
  logic               r_point_valid;
  logic               r_fail;
  logic [7:0]         r_retry_cnt;
  logic               r_mode_game_q;

  logic       w_in_game;
  logic       w_eat_evt;
  logic       w_reject;
  logic       w_guard_hit;
  logic       w_retry_last;
  logic [7:0] w_retry_inc;

  assign w_in_game    = (mode == GAME);
  // An eat only counts while a point is live and the FSM is parked in IDLE.
  assign w_eat_evt    = w_in_game && (r_state == ST_IDLE) && r_point_valid && tick && (eat_p1 || eat_p2);
  assign w_retry_inc  = r_retry_cnt + 8'd1;
  assign w_retry_last = (w_retry_inc == 8'(MAX_RETRY));
  assign w_reject     = occ_hit || (32'(r_cand.x) >= GRID_X) || (32'(r_cand.y) >= GRID_Y) || w_guard_hit;

`ifdef POINT_SCHED_SPAWN_GUARD_EN
  logic [5:0] w_dist1;
  logic [5:0] w_dist2;
  assign w_dist1     = absdiff6(r_cand.x, head1_x) + absdiff6(r_cand.y, head1_y);
  assign w_dist2     = absdiff6(r_cand.x, head2_x) + absdiff6(r_cand.y, head2_y);
  assign w_guard_hit = (w_dist1 <= 6'd1) || (w_dist2 <= 6'd1);
`else
  logic w_unused_heads;
  assign w_unused_heads = ^{head1_x, head1_y, head2_x, head2_y};
  assign w_guard_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; leaving GAME overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_in_game) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if ((!r_point_valid && !r_fail) || w_eat_evt) w_state_nxt = ST_REQ;
        ST_REQ:      w_state_nxt = ST_WAIT_RDY;
        ST_WAIT_RDY: if (gen_rdy) w_state_nxt = ST_CHECK;
        ST_CHECK:    w_state_nxt = ST_EVAL;
        ST_EVAL:     begin
          if (!w_reject)        w_state_nxt = ST_PUBLISH;
          else if (w_retry_last) w_state_nxt = ST_FAIL;
          else                   w_state_nxt = ST_REQ;
        end
        ST_PUBLISH:  w_state_nxt = ST_IDLE;
        ST_FAIL:     w_state_nxt = ST_FAIL;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: the accepted point is loaded on the EVAL->PUBLISH edge so it is already live during PUBLISH.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      r_cand        <= '0;
      r_point       <= '0;
      r_point_valid <= 1'b0;
      r_fail        <= 1'b0;
      r_retry_cnt   <= 8'd0;
      r_mode_game_q <= 1'b0;
    end else begin
      r_mode_game_q <= w_in_game;
      if (!w_in_game) begin
        r_point_valid <= 1'b0;
        r_fail        <= 1'b0;
        r_retry_cnt   <= 8'd0;
      end else begin
        if ((r_state == ST_WAIT_RDY) && gen_rdy) begin
          r_cand.x <= gen_x;
          r_cand.y <= gen_y;
        end
        if (w_eat_evt) begin
          r_point_valid <= 1'b0;
        end
        if (r_state == ST_EVAL) begin
          if (w_reject) begin
            r_retry_cnt <= w_retry_inc;
            if (w_retry_last) begin
              r_fail <= 1'b1;
            end
          end else begin
            r_point       <= r_cand;
            r_point_valid <= 1'b1;
            r_retry_cnt   <= 8'd0;
          end
        end
      end
    end
  end

  point_score_ctr #(.W(SCORE_W)) u_score_p1 (
    .i_clk (clk_75),
    .i_rst (rst),
    .i_clr (w_in_game && !r_mode_game_q),
    .i_inc (w_eat_evt && eat_p1),
    .o_cnt (score_p1)
  );

  point_score_ctr #(.W(SCORE_W)) u_score_p2 (
    .i_clk (clk_75),
    .i_rst (rst),
    .i_clr (w_in_game && !r_mode_game_q),
    .i_inc (w_eat_evt && eat_p2),
    .o_cnt (score_p2)
  );

  assign gen_req     = (r_state == ST_REQ);
  assign occ_x       = r_cand.x;
  assign occ_y       = r_cand.y;
  assign point_x     = r_point.x;
  assign point_y     = r_point.y;
  assign point_valid = r_point_valid;
  assign fail        = r_fail;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_FAIL);

endmodule
